// File: rtl/wm_pkg.sv
// ---------------------------------------------------------------------------
// wm_pkg
//   Shared definitions for the wash-program sequencer family.
//   - Phase encoding (also presented on the controller's phase output).
//   - Default phase durations in clock cycles.
//   - Default timer and repeat-count widths.
// ---------------------------------------------------------------------------
package wm_pkg;

    // Phase encoding; 3'd7 is intentionally unused.
    localparam logic [2:0] PH_IDLE        = 3'd0;
    localparam logic [2:0] PH_FILL_WATER  = 3'd1;
    localparam logic [2:0] PH_WASH        = 3'd2;
    localparam logic [2:0] PH_RINSE       = 3'd3;
    localparam logic [2:0] PH_SPIN        = 3'd4;
    localparam logic [2:0] PH_DRY         = 3'd5;
    localparam logic [2:0] PH_STEAM_CLEAN = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE        = PH_IDLE,
        ST_FILL_WATER  = PH_FILL_WATER,
        ST_WASH        = PH_WASH,
        ST_RINSE       = PH_RINSE,
        ST_SPIN        = PH_SPIN,
        ST_DRY         = PH_DRY,
        ST_STEAM_CLEAN = PH_STEAM_CLEAN
    } wm_state_e;

    // Default widths.
    localparam int CNT_W_DEF = 8;
    localparam int REP_W_DEF = 2;

    // Default phase durations, in clock cycles (each must be >= 1).
    localparam int T_FILL_DEF  = 7;
    localparam int T_WASH_DEF  = 5;
    localparam int T_RINSE_DEF = 5;
    localparam int T_SPIN_DEF  = 5;
    localparam int T_DRY_DEF   = 10;
    localparam int T_STEAM_DEF = 10;

endpackage

// File: rtl/wm_phase_timer.sv
// ---------------------------------------------------------------------------
// wm_phase_timer
//   Phase down-counter: clear, load, decrement-to-zero or hold.
//   Priority: clear > load > decrement. Decrement stops at zero.
//
// Parameters
//   CNT_W       counter width
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous, active-low reset
//   i_clear     in   1      force count to 0
//   i_load      in   1      load i_load_val
//   i_load_val  in   CNT_W  value loaded on i_load
//   i_dec       in   1      decrement by one (ignored at zero)
//   o_count     out  CNT_W  current count
//   o_zero      out  1      count == 0
// ---------------------------------------------------------------------------
module wm_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/wash_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// wash_cycle_ctrl
//   Parametrised wash-program sequencer between the front-panel decoder and
//   the actuator drivers. Runs fill, N wash/rinse passes, spin and optional
//   dry, with pause (exact resume) and abort.
//
//   Build option: define WM_STEAM_EN to enable the steam program
//   (STEAM_CLEAN phase selected by steam_mode at start). Without it,
//   steam_mode is ignored and STEAM_CLEAN is unreachable.
//
//   state          | meaning
//   ---------------+-----------------------------------------------
//   IDLE        0  | waiting for start; outputs quiet
//   FILL_WATER  1  | filling drum, T_FILL cycles
//   WASH        2  | wash pass, T_WASH cycles
//   RINSE       3  | rinse pass, T_RINSE cycles; loops to WASH per pass
//   SPIN        4  | spin, T_SPIN cycles; then DRY or done
//   DRY         5  | dry, T_DRY cycles; then done
//   STEAM_CLEAN 6  | steam program, T_STEAM cycles; then done
//   (7)            | illegal; recovers to IDLE on next edge
//
// Parameters
//   CNT_W, REP_W, T_FILL, T_WASH, T_RINSE, T_SPIN, T_DRY, T_STEAM
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous, active-low reset
//   start       in   1      level; sampled only in IDLE
//   repeat_cnt  in   REP_W  wash+rinse passes (0 behaves as 1), latched at start
//   dry_en      in   1      run DRY after SPIN, latched at start
//   steam_mode  in   1      steam program (WM_STEAM_EN builds only)
//   pause       in   1      freeze current phase while high
//   abort       in   1      return to IDLE without done; blocks start
//   busy        out  1      any non-IDLE phase
//   paused      out  1      registered busy & pause
//   done        out  1      one-cycle pulse on normal completion
//   phase       out  3      current phase encoding
//   remaining   out  CNT_W  cycles left in phase minus 1; 0 in IDLE
// ---------------------------------------------------------------------------
module wash_cycle_ctrl
    import wm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int REP_W   = REP_W_DEF,
    parameter int T_FILL  = T_FILL_DEF,
    parameter int T_WASH  = T_WASH_DEF,
    parameter int T_RINSE = T_RINSE_DEF,
    parameter int T_SPIN  = T_SPIN_DEF,
    parameter int T_DRY   = T_DRY_DEF,
    parameter int T_STEAM = T_STEAM_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic             dry_en,
    input  logic             steam_mode,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    wm_state_e        r_state;
    logic [REP_W-1:0] r_pass;
    logic [REP_W-1:0] r_reps;
    logic             r_dry;
    logic             r_busy;
    logic             r_paused;
    logic             r_done;

    wm_state_e        w_next_state;
    wm_state_e        w_succ;
    wm_state_e        w_start_phase;
    logic             w_illegal;
    logic             w_active;
    logic             w_run;
    logic             w_tick;
    logic             w_finish;
    logic             w_start;
    logic             w_more;
    logic [REP_W-1:0] w_reps_eff;
    logic [REP_W:0]   w_pass_inc;

    logic [CNT_W-1:0] w_tmr_count;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic             w_tmr_clear;
    logic             w_tmr_load;
    logic             w_tmr_dec;

    // Timer reload value for a phase: it counts T_x-1 down to 0, so the
    // phase occupies exactly T_x unpaused cycles.
    function automatic logic [CNT_W-1:0] f_load_val(input wm_state_e s);
        case (s)
            ST_FILL_WATER:  f_load_val = CNT_W'(T_FILL - 1);
            ST_WASH:        f_load_val = CNT_W'(T_WASH - 1);
            ST_RINSE:       f_load_val = CNT_W'(T_RINSE - 1);
            ST_SPIN:        f_load_val = CNT_W'(T_SPIN - 1);
            ST_DRY:         f_load_val = CNT_W'(T_DRY - 1);
            ST_STEAM_CLEAN: f_load_val = CNT_W'(T_STEAM - 1);
            default:        f_load_val = '0;
        endcase
    endfunction

    wm_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_tmr_clear),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

`ifndef WM_STEAM_EN
    logic w_unused_steam;
    assign w_unused_steam = steam_mode;
`endif

    always_comb begin
        w_illegal     = 1'b0;
        w_succ        = ST_IDLE;
        w_finish      = 1'b0;
        w_reps_eff    = (r_reps == '0) ? REP_W'(1) : r_reps;
        w_pass_inc    = {1'b0, r_pass} + (REP_W+1)'(1);
        w_more        = (w_pass_inc < {1'b0, w_reps_eff});

        // Successor taken when the current phase's timer expires.
        case (r_state)
            ST_IDLE:       w_succ = ST_IDLE;
            ST_FILL_WATER: w_succ = ST_WASH;
            ST_WASH:       w_succ = ST_RINSE;
            ST_RINSE:      w_succ = w_more ? ST_WASH : ST_SPIN;
            ST_SPIN: begin
                if (r_dry) begin
                    w_succ = ST_DRY;
                end else begin
                    w_succ   = ST_IDLE;
                    w_finish = 1'b1;
                end
            end
            ST_DRY: begin
                w_succ   = ST_IDLE;
                w_finish = 1'b1;
            end
`ifdef WM_STEAM_EN
            ST_STEAM_CLEAN: begin
                w_succ   = ST_IDLE;
                w_finish = 1'b1;
            end
`endif
            default:       w_illegal = 1'b1;
        endcase

        w_active = (r_state != ST_IDLE) && !w_illegal;
        // abort outranks pause: an aborting cycle is never a frozen one.
        w_run    = w_active && !abort && !pause;
        w_tick   = w_run && w_tmr_zero;
        w_start  = (r_state == ST_IDLE) && start && !abort;

`ifdef WM_STEAM_EN
        w_start_phase = steam_mode ? ST_STEAM_CLEAN : ST_FILL_WATER;
`else
        w_start_phase = ST_FILL_WATER;
`endif

        w_next_state = r_state;
        if (w_illegal) begin
            w_next_state = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            if (w_start) begin
                w_next_state = w_start_phase;
            end
        end else if (abort) begin
            w_next_state = ST_IDLE;
        end else if (w_tick) begin
            w_next_state = w_succ;
        end

        w_tmr_clear = (r_state != ST_IDLE) && (w_next_state == ST_IDLE);
        w_tmr_load  = w_start || (w_tick && (w_succ != ST_IDLE));
        w_tmr_val   = f_load_val(w_start ? w_start_phase : w_succ);
        w_tmr_dec   = w_run && !w_tmr_zero;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pass   <= '0;
            r_reps   <= '0;
            r_dry    <= 1'b0;
            r_busy   <= 1'b0;
            r_paused <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= (w_next_state != ST_IDLE);
            r_paused <= w_active && pause && !abort;
            r_done   <= w_tick && w_finish;

            if (w_start) begin
                r_reps <= repeat_cnt;
                r_dry  <= dry_en;
                r_pass <= '0;
            end else if (w_next_state == ST_IDLE) begin
                r_pass <= '0;
            end else if (w_tick && (r_state == ST_RINSE) && w_more) begin
                r_pass <= r_pass + REP_W'(1);
            end
        end
    end

    assign busy      = r_busy;
    assign paused    = r_paused;
    assign done      = r_done;
    assign phase     = r_state;
    assign remaining = w_tmr_count;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
module tb_wash_cycle_ctrl;
    import wm_pkg::*;

    localparam int CNT_W = 8;
    localparam int REP_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [REP_W-1:0] repeat_cnt = '0;
    logic             dry_en = 1'b0;
    logic             steam_mode = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             paused;
    logic             done;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remaining;

    wash_cycle_ctrl #(
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .dry_en     (dry_en),
        .steam_mode (steam_mode),
        .pause      (pause),
        .abort      (abort),
        .busy       (busy),
        .paused     (paused),
        .done       (done),
        .phase      (phase),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a plan of phases ----------------
    int m_phase = 0;
    int m_left  = 0;
    int m_plan[$];
    bit m_done   = 1'b0;
    bit m_paused = 1'b0;

    function automatic int dur(input int p);
        case (p)
            1: return 7;
            2: return 5;
            3: return 5;
            4: return 5;
            5: return 10;
            6: return 10;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit stm;
        int reps;
        m_done   = 1'b0;
        m_paused = (m_phase != 0) && pause && !abort;
        if (m_phase == 0) begin
            if (start && !abort) begin
                stm = 1'b0;
`ifdef WM_STEAM_EN
                stm = steam_mode;
`endif
                m_plan.delete();
                if (stm) begin
                    m_plan.push_back(6);
                end else begin
                    reps = (repeat_cnt == 0) ? 1 : int'(repeat_cnt);
                    m_plan.push_back(1);
                    for (int i = 0; i < reps; i++) begin
                        m_plan.push_back(2);
                        m_plan.push_back(3);
                    end
                    m_plan.push_back(4);
                    if (dry_en) m_plan.push_back(5);
                end
                m_phase = m_plan.pop_front();
                m_left  = dur(m_phase);
            end
        end else if (abort) begin
            m_phase = 0;
            m_left  = 0;
            m_plan.delete();
        end else if (!pause) begin
            if (m_left > 1) begin
                m_left--;
            end else if (m_plan.size() == 0) begin
                m_phase = 0;
                m_left  = 0;
                m_done  = 1'b1;
            end else begin
                m_phase = m_plan.pop_front();
                m_left  = dur(m_phase);
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase  = 0;
            m_left   = 0;
            m_done   = 1'b0;
            m_paused = 1'b0;
            m_plan.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("phase",     int'(phase),     m_phase);
        chk("remaining", int'(remaining), (m_phase == 0) ? 0 : m_left - 1);
        chk("busy",      int'(busy),      int'(m_phase != 0));
        chk("paused",    int'(paused),    int'(m_paused));
        chk("done",      int'(done),      int'(m_done));
    end

    // ---------------- phase-entry / done log for literal timing ----------
    int cyc = 0;
    int last_p = 0;
    int log_p[$];
    int log_c[$];
    int done_c[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (int'(phase) != last_p) begin
            log_p.push_back(int'(phase));
            log_c.push_back(cyc);
            last_p = int'(phase);
        end
        if (done) done_c.push_back(cyc);
    end

    task automatic clear_log();
        log_p.delete();
        log_c.delete();
        done_c.delete();
    endtask

    task automatic chk_log(input string name, input int ep[8], input int ec[8],
                           input int n, input int edone);
        int e0;
        chk({name, " entries"}, log_p.size(), n);
        e0 = (log_c.size() > 0) ? log_c[0] : 0;
        if (log_p.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({name, " phase seq"}, log_p[i], ep[i]);
                chk({name, " phase at"},  log_c[i] - e0, ec[i]);
            end
        end
        if (edone < 0) begin
            chk({name, " done count"}, done_c.size(), 0);
        end else begin
            chk({name, " done count"}, done_c.size(), 1);
            if (done_c.size() == 1) chk({name, " done at"}, done_c[0] - e0, edone);
        end
    endtask

    task automatic launch(input int rep, input bit dry, input bit stm);
        @(negedge clk);
        repeat_cnt = REP_W'(rep);
        dry_en     = dry;
        steam_mode = stm;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        // Latched at start; these changes must be ignored.
        repeat_cnt = ~repeat_cnt;
        dry_en     = ~dry_en;
        steam_mode = ~steam_mode;
    endtask

    task automatic wait_phase(input int p, input int budget, input string name);
        int k = 0;
        while (int'(phase) != p && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, " reached phase"}, int'(phase), p);
    endtask

    task automatic finish_prog(input string name);
        wait_phase(0, 200, name);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset phase",     int'(phase), 0);
        chk("reset busy",      int'(busy), 0);
        chk("reset remaining", int'(remaining), 0);
        chk("reset done",      int'(done), 0);
        chk("reset paused",    int'(paused), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single pass with dry
        clear_log();
        launch(1, 1'b1, 1'b0);
        finish_prog("t2");
        chk_log("t2", '{1, 2, 3, 4, 5, 0, 0, 0}, '{0, 7, 12, 17, 22, 32, 0, 0}, 6, 32);

        // Two passes, no dry, with a start pulse while busy
        clear_log();
        launch(2, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_prog("t3a");
        chk_log("t3a", '{1, 2, 3, 2, 3, 4, 0, 0}, '{0, 7, 12, 17, 22, 27, 32, 0}, 7, 32);

        // repeat_cnt = 0 behaves as 1
        clear_log();
        launch(0, 1'b0, 1'b0);
        finish_prog("t3b");
        chk_log("t3b", '{1, 2, 3, 4, 0, 0, 0, 0}, '{0, 7, 12, 17, 22, 0, 0, 0}, 5, 22);

        // Pause in IDLE has no effect, then a 20-cycle pause in WASH
        pause = 1'b1;
        repeat (3) @(negedge clk);
        pause = 1'b0;
        clear_log();
        launch(1, 1'b1, 1'b0);
        wait_phase(2, 20, "t4");
        for (int k = 0; k < 10 && int'(remaining) != 2; k++) @(negedge clk);
        chk("t4 pause point", int'(remaining), 2);
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t4 held phase",     int'(phase), 2);
            chk("t4 held remaining", int'(remaining), 2);
            chk("t4 held paused",    int'(paused), 1);
        end
        pause = 1'b0;
        finish_prog("t4");
        chk_log("t4", '{1, 2, 3, 4, 5, 0, 0, 0}, '{0, 7, 32, 37, 42, 52, 0, 0}, 6, 52);

        // Abort (together with pause) in RINSE
        clear_log();
        launch(1, 1'b0, 1'b0);
        wait_phase(3, 30, "t5");
        abort = 1'b1;
        pause = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pause = 1'b0;
        chk("t5 abort phase", int'(phase), 0);
        chk("t5 abort busy",  int'(busy), 0);
        repeat (5) @(negedge clk);
        chk_log("t5", '{1, 2, 3, 0, 0, 0, 0, 0}, '{0, 7, 12, 13, 0, 0, 0, 0}, 4, -1);

        // start held with abort in IDLE stays IDLE
        repeat_cnt = 2'd1;
        dry_en     = 1'b0;
        steam_mode = 1'b0;
        start      = 1'b1;
        abort      = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t5 blocked start", int'(phase), 0);
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);

        // Steam request
        clear_log();
        launch(1, 1'b1, 1'b1);
        finish_prog("t6");
`ifdef WM_STEAM_EN
        chk_log("t6", '{6, 0, 0, 0, 0, 0, 0, 0}, '{0, 10, 0, 0, 0, 0, 0, 0}, 2, 10);
`else
        chk_log("t6", '{1, 2, 3, 4, 5, 0, 0, 0}, '{0, 7, 12, 17, 22, 32, 0, 0}, 6, 32);
`endif

        // Asynchronous reset mid-WASH
        launch(1, 1'b0, 1'b0);
        wait_phase(2, 20, "t1");
        #2;
        rst = 1'b0;
        #1;
        chk("t1 async phase",     int'(phase), 0);
        chk("t1 async busy",      int'(busy), 0);
        chk("t1 async done",      int'(done), 0);
        chk("t1 async remaining", int'(remaining), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
